id_ex_stage: RTL and testbench

ID_EX_STAGE -- requirements
Module: id_ex_stage

---
 rtl/ve370_pkg.sv | 43 ++++
 rtl/fwd_mux.sv | 42 ++++
 rtl/id_ex_stage.sv | 120 ++++++++++++
 tb/tb_id_ex_stage.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ve370_pkg.sv
// Shared definitions for the ID/EX stage: ALU op codes, forwarding select,
// the stored pipeline-register layout and the forwarding match helper.
package ve370_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    typedef enum logic [1:0] {
        FWD_REG   = 2'b00,
        FWD_EXMEM = 2'b01,
        FWD_MEMWB = 2'b10
    } fwd_sel_e;

    typedef struct packed {
        logic        valid;
        logic [3:0]  alu_control;
        logic        alu_src;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic [4:0]  dest;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [31:0] rs_data;
        logic [31:0] rt_data;
        logic [31:0] imm;
    } idex_regs_t;

    // A bubble is all-zero, which also makes its ALU op an AND.
    localparam idex_regs_t IDEX_BUBBLE = '0;

    // $0 is hard-wired, so a write to it never produces a forwardable value.
    function automatic logic fwd_hit(input logic       reg_write,
                                     input logic [4:0] rd,
                                     input logic [4:0] idx);
        return reg_write && (rd != 5'd0) && (rd == idx);
    endfunction

endpackage

// File: rtl/fwd_mux.sv
// Selects the freshest value for one source operand: EX/MEM result, then
// MEM/WB result, then the value read from the register file in ID.
module fwd_mux
    import ve370_pkg::*;
(
    input  logic [4:0]  src_idx,
    input  logic [31:0] src_data,
    input  logic        exmem_reg_write,
    input  logic [4:0]  exmem_rd,
    input  logic [31:0] exmem_result,
    input  logic        memwb_reg_write,
    input  logic [4:0]  memwb_rd,
    input  logic [31:0] memwb_result,
    output logic [31:0] fwd_data
);

    fwd_sel_e sel_s;

    // Younger producer (EX/MEM) wins when both stages target the same index
    always_comb begin
        sel_s = FWD_REG;
        if (fwd_hit(exmem_reg_write, exmem_rd, src_idx)) begin
            sel_s = FWD_EXMEM;
        end else if (fwd_hit(memwb_reg_write, memwb_rd, src_idx)) begin
            sel_s = FWD_MEMWB;
        end else begin
            sel_s = FWD_REG;
        end
    end

    // Operand data mux driven by the select above
    always_comb begin
        fwd_data = src_data;
        case (sel_s)
            FWD_EXMEM: fwd_data = exmem_result;
            FWD_MEMWB: fwd_data = memwb_result;
            FWD_REG:   fwd_data = src_data;
            default:   fwd_data = src_data;
        endcase
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding and load-use detection
// for a 32-bit five-stage MIPS-style pipeline.
module id_ex_stage
    import ve370_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        flush,
    input  logic        id_valid,
    input  logic [3:0]  id_alu_control,
    input  logic [31:0] id_rs_data,
    input  logic [31:0] id_rt_data,
    input  logic [31:0] id_imm,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic [4:0]  id_rd,
    input  logic        id_alu_src,
    input  logic        id_reg_dst,
    input  logic        id_reg_write,
    input  logic        id_mem_read,
    input  logic        id_mem_write,
    input  logic        exmem_reg_write,
    input  logic [4:0]  exmem_rd,
    input  logic [31:0] exmem_result,
    input  logic        memwb_reg_write,
    input  logic [4:0]  memwb_rd,
    input  logic [31:0] memwb_result,
    output logic [3:0]  alu_control,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [31:0] ex_wdata,
    output logic [4:0]  ex_dest,
    output logic        ex_valid,
    output logic        ex_reg_write,
    output logic        ex_mem_read,
    output logic        ex_mem_write,
    output logic        load_use_stall
);

    idex_regs_t stage_r;
    idex_regs_t next_s;
    logic [31:0] fwd_rs_s;
    logic [31:0] fwd_rt_s;

    // A load in EX cannot feed the instruction in ID without one bubble
    always_comb begin
        load_use_stall = stage_r.valid && stage_r.mem_read && (stage_r.dest != 5'd0)
                      && id_valid && ((stage_r.dest == id_rs) || (stage_r.dest == id_rt));
    end

    // Next-state selection: flush > stall > load-use > capture
    always_comb begin
        next_s = stage_r;
        if (flush) begin
            next_s = IDEX_BUBBLE;
        end else if (stall) begin
            next_s = stage_r;
        end else if (load_use_stall || !id_valid) begin
            next_s = IDEX_BUBBLE;
        end else begin
            next_s.valid       = 1'b1;
            next_s.alu_control = id_alu_control;
            next_s.alu_src     = id_alu_src;
            next_s.reg_write   = id_reg_write;
            next_s.mem_read    = id_mem_read;
            next_s.mem_write   = id_mem_write;
            next_s.dest        = id_reg_dst ? id_rd : id_rt;
            next_s.rs          = id_rs;
            next_s.rt          = id_rt;
            next_s.rs_data     = id_rs_data;
            next_s.rt_data     = id_rt_data;
            next_s.imm         = id_imm;
        end
    end

    // Pipeline register; reset clears to a bubble without waiting for clk
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_r <= IDEX_BUBBLE;
        end else begin
            stage_r <= next_s;
        end
    end

    fwd_mux u_fwd_rs (
        .src_idx         (stage_r.rs),
        .src_data        (stage_r.rs_data),
        .exmem_reg_write (exmem_reg_write),
        .exmem_rd        (exmem_rd),
        .exmem_result    (exmem_result),
        .memwb_reg_write (memwb_reg_write),
        .memwb_rd        (memwb_rd),
        .memwb_result    (memwb_result),
        .fwd_data        (fwd_rs_s)
    );

    fwd_mux u_fwd_rt (
        .src_idx         (stage_r.rt),
        .src_data        (stage_r.rt_data),
        .exmem_reg_write (exmem_reg_write),
        .exmem_rd        (exmem_rd),
        .exmem_result    (exmem_result),
        .memwb_reg_write (memwb_reg_write),
        .memwb_rd        (memwb_rd),
        .memwb_result    (memwb_result),
        .fwd_data        (fwd_rt_s)
    );

    assign alu_control  = stage_r.alu_control;
    assign alu_a        = fwd_rs_s;
    assign alu_b        = stage_r.alu_src ? stage_r.imm : fwd_rt_s;
    assign ex_wdata     = fwd_rt_s;
    assign ex_dest      = stage_r.dest;
    assign ex_valid     = stage_r.valid;
    assign ex_reg_write = stage_r.reg_write;
    assign ex_mem_read  = stage_r.mem_read;
    assign ex_mem_write = stage_r.mem_write;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage with hand-computed expectations.
module tb_id_ex_stage;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        flush;
    logic        id_valid;
    logic [3:0]  id_alu_control;
    logic [31:0] id_rs_data;
    logic [31:0] id_rt_data;
    logic [31:0] id_imm;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic [4:0]  id_rd;
    logic        id_alu_src;
    logic        id_reg_dst;
    logic        id_reg_write;
    logic        id_mem_read;
    logic        id_mem_write;
    logic        exmem_reg_write;
    logic [4:0]  exmem_rd;
    logic [31:0] exmem_result;
    logic        memwb_reg_write;
    logic [4:0]  memwb_rd;
    logic [31:0] memwb_result;
    logic [3:0]  alu_control;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [31:0] ex_wdata;
    logic [4:0]  ex_dest;
    logic        ex_valid;
    logic        ex_reg_write;
    logic        ex_mem_read;
    logic        ex_mem_write;
    logic        load_use_stall;

    int n_checks;
    int n_fail;

    id_ex_stage dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .stall           (stall),
        .flush           (flush),
        .id_valid        (id_valid),
        .id_alu_control  (id_alu_control),
        .id_rs_data      (id_rs_data),
        .id_rt_data      (id_rt_data),
        .id_imm          (id_imm),
        .id_rs           (id_rs),
        .id_rt           (id_rt),
        .id_rd           (id_rd),
        .id_alu_src      (id_alu_src),
        .id_reg_dst      (id_reg_dst),
        .id_reg_write    (id_reg_write),
        .id_mem_read     (id_mem_read),
        .id_mem_write    (id_mem_write),
        .exmem_reg_write (exmem_reg_write),
        .exmem_rd        (exmem_rd),
        .exmem_result    (exmem_result),
        .memwb_reg_write (memwb_reg_write),
        .memwb_rd        (memwb_rd),
        .memwb_result    (memwb_result),
        .alu_control     (alu_control),
        .alu_a           (alu_a),
        .alu_b           (alu_b),
        .ex_wdata        (ex_wdata),
        .ex_dest         (ex_dest),
        .ex_valid        (ex_valid),
        .ex_reg_write    (ex_reg_write),
        .ex_mem_read     (ex_mem_read),
        .ex_mem_write    (ex_mem_write),
        .load_use_stall  (load_use_stall)
    );

    // 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic [3:0] ctl, input logic [4:0] rs, input logic [4:0] rt,
                          input logic [4:0] rd, input logic [31:0] rs_d, input logic [31:0] rt_d);
        id_valid       = 1'b1;
        id_alu_control = ctl;
        id_rs          = rs;
        id_rt          = rt;
        id_rd          = rd;
        id_rs_data     = rs_d;
        id_rt_data     = rt_d;
    endtask

    task automatic clear_fwd();
        exmem_reg_write = 1'b0;
        exmem_rd        = 5'd0;
        exmem_result    = 32'd0;
        memwb_reg_write = 1'b0;
        memwb_rd        = 5'd0;
        memwb_result    = 32'd0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n = 1'b0;
        stall = 1'b0;
        flush = 1'b0;
        id_valid = 1'b0;
        id_alu_control = 4'd0;
        id_rs_data = 32'd0;
        id_rt_data = 32'd0;
        id_imm = 32'd0;
        id_rs = 5'd0;
        id_rt = 5'd0;
        id_rd = 5'd0;
        id_alu_src = 1'b0;
        id_reg_dst = 1'b0;
        id_reg_write = 1'b0;
        id_mem_read = 1'b0;
        id_mem_write = 1'b0;
        clear_fwd();

        #12;
        check_eq("rst_valid", {31'd0, ex_valid}, 32'd0);
        check_eq("rst_alu_control", {28'd0, alu_control}, 32'd0);
        check_eq("rst_dest", {27'd0, ex_dest}, 32'd0);
        check_eq("rst_alu_a", alu_a, 32'd0);
        check_eq("rst_load_use", {31'd0, load_use_stall}, 32'd0);
        rst_n = 1'b1;

        // basic ADD capture, rd as destination
        set_id(4'b0010, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7);
        id_reg_dst = 1'b1;
        id_reg_write = 1'b1;
        tick();
        check_eq("cap_alu_control", {28'd0, alu_control}, 32'h2);
        check_eq("cap_alu_a", alu_a, 32'd5);
        check_eq("cap_alu_b", alu_b, 32'd7);
        check_eq("cap_dest_rd", {27'd0, ex_dest}, 32'd3);
        check_eq("cap_valid", {31'd0, ex_valid}, 32'd1);
        check_eq("cap_reg_write", {31'd0, ex_reg_write}, 32'd1);

        // immediate operand, rt as destination; wdata still rt value
        set_id(4'b0110, 5'd1, 5'd4, 5'd3, 32'd5, 32'd9);
        id_reg_dst = 1'b0;
        id_alu_src = 1'b1;
        id_imm = 32'hFFFF_FFF0;
        tick();
        check_eq("imm_dest_rt", {27'd0, ex_dest}, 32'd4);
        check_eq("imm_alu_b", alu_b, 32'hFFFF_FFF0);
        check_eq("imm_wdata", ex_wdata, 32'd9);
        check_eq("imm_alu_control", {28'd0, alu_control}, 32'h6);

        // forwarding priority on rs=8
        set_id(4'b0010, 5'd8, 5'd0, 5'd3, 32'h33, 32'h0);
        id_alu_src = 1'b0;
        tick();
        exmem_reg_write = 1'b1; exmem_rd = 5'd8; exmem_result = 32'h11;
        memwb_reg_write = 1'b1; memwb_rd = 5'd8; memwb_result = 32'h22;
        #1;
        check_eq("fwd_exmem_wins", alu_a, 32'h11);
        exmem_reg_write = 1'b0;
        #1;
        check_eq("fwd_memwb", alu_a, 32'h22);
        memwb_reg_write = 1'b0;
        #1;
        check_eq("fwd_none", alu_a, 32'h33);
        clear_fwd();

        // zero register never forwarded; rt forwarded from MEM/WB
        set_id(4'b0010, 5'd0, 5'd6, 5'd3, 32'h44, 32'h55);
        tick();
        exmem_reg_write = 1'b1; exmem_rd = 5'd0; exmem_result = 32'hFF;
        memwb_reg_write = 1'b1; memwb_rd = 5'd6; memwb_result = 32'h66;
        #1;
        check_eq("zero_no_fwd", alu_a, 32'h44);
        check_eq("rt_fwd_wdata", ex_wdata, 32'h66);
        check_eq("rt_fwd_alu_b", alu_b, 32'h66);
        clear_fwd();

        // load-use: lw $9 in EX, ID reads $9 as rt
        set_id(4'b0010, 5'd1, 5'd9, 5'd0, 32'h0, 32'h0);
        id_mem_read = 1'b1;
        tick();
        check_eq("lw_mem_read", {31'd0, ex_mem_read}, 32'd1);
        check_eq("lw_dest", {27'd0, ex_dest}, 32'd9);
        set_id(4'b0010, 5'd2, 5'd9, 5'd3, 32'h10, 32'h20);
        id_mem_read = 1'b0;
        id_reg_dst = 1'b1;
        #1;
        check_eq("lu_stall_hit", {31'd0, load_use_stall}, 32'd1);
        id_valid = 1'b0;
        #1;
        check_eq("lu_stall_invalid", {31'd0, load_use_stall}, 32'd0);
        id_rt = 5'd5;
        id_valid = 1'b1;
        #1;
        check_eq("lu_stall_miss", {31'd0, load_use_stall}, 32'd0);
        id_rt = 5'd9;
        #1;
        tick();
        check_eq("lu_bubble_valid", {31'd0, ex_valid}, 32'd0);
        check_eq("lu_bubble_ctl", {28'd0, alu_control}, 32'd0);
        check_eq("lu_cleared", {31'd0, load_use_stall}, 32'd0);
        tick();
        check_eq("lu_retry_valid", {31'd0, ex_valid}, 32'd1);
        check_eq("lu_retry_alu_a", alu_a, 32'h10);

        // stall holds for three edges while forwarding stays live
        stall = 1'b1;
        set_id(4'b0110, 5'd7, 5'd7, 5'd7, 32'hAA, 32'hBB);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("stall_alu_a", alu_a, 32'h10);
            check_eq("stall_ctl", {28'd0, alu_control}, 32'h2);
            check_eq("stall_valid", {31'd0, ex_valid}, 32'd1);
        end
        exmem_reg_write = 1'b1; exmem_rd = 5'd2; exmem_result = 32'h77;
        #1;
        check_eq("stall_fwd_live", alu_a, 32'h77);
        clear_fwd();

        // flush beats stall
        flush = 1'b1;
        tick();
        check_eq("flush_valid", {31'd0, ex_valid}, 32'd0);
        check_eq("flush_ctl", {28'd0, alu_control}, 32'd0);
        check_eq("flush_dest", {27'd0, ex_dest}, 32'd0);
        check_eq("flush_alu_a", alu_a, 32'd0);
        flush = 1'b0;
        stall = 1'b0;

        // invalid ID slot captures a bubble
        id_valid = 1'b0;
        id_reg_write = 1'b1;
        tick();
        check_eq("invalid_valid", {31'd0, ex_valid}, 32'd0);
        check_eq("invalid_reg_write", {31'd0, ex_reg_write}, 32'd0);

        // async reset between edges
        set_id(4'b0001, 5'd1, 5'd2, 5'd3, 32'h1, 32'h2);
        tick();
        check_eq("pre_rst_reg_write", {31'd0, ex_reg_write}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("async_rst_valid", {31'd0, ex_valid}, 32'd0);
        check_eq("async_rst_reg_write", {31'd0, ex_reg_write}, 32'd0);
        check_eq("async_rst_ctl", {28'd0, alu_control}, 32'd0);
        rst_n = 1'b1;
        tick();
        check_eq("post_rst_capture", {28'd0, alu_control}, 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
